// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clk_div_pkg;

    localparam int unsigned DIV_MIN = 2;

    typedef enum logic {StStop, StRun} run_state_e;

    function automatic int unsigned clamp_div(input int unsigned d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

    // Number of posedge cycles the phase flop stays high: ceil(D/2).
    function automatic int unsigned half_hi(input int unsigned d);
        return (d + 1) / 2;
    endfunction

endpackage

// File: rtl/clk_div_oddfix.sv
// Falling-edge trim flop and even/odd output select for the divided clock.
module clk_div_oddfix (
    input  logic clk,
    input  logic rst,
    input  logic p,
    input  logic cut,
    input  logic odd,
    output logic clk_out
);
    logic n_q;

    // n drops half a cycle before p falls on odd divisors, so the high phase ends on a
    // falling edge while the rise stays on the posedge that also raises tick.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            n_q <= 1'b0;
        end else begin
            n_q <= ~cut;
        end
    end

    assign clk_out = odd ? (p & n_q) : p;

endmodule

// File: rtl/prog_clock_divider.sv
// Programmable integer clock divider with boundary-aligned divisor changes, run/stop
// control and a free-running power-of-two tap counter.
module prog_clock_divider
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W     = 8,
    parameter int unsigned DIV_RESET = 4,
    parameter int unsigned NUM_TAPS  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [DIV_W-1:0]    div_i,
    input  logic                div_load,
    output logic                clk_out,
    output logic                tick,
    output logic                busy,
    output logic [NUM_TAPS-1:0] taps
);
    localparam logic [DIV_W-1:0] DivRst = DIV_W'(clamp_div(DIV_RESET));

    run_state_e          state_q, state_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [DIV_W-1:0]    act_q, act_d;
    logic [DIV_W-1:0]    pend_q, pend_d;
    logic [DIV_W-1:0]    half_q, half_d;
    logic                busy_q, busy_d;
    logic                p_q, p_d;
    logic                tick_q, tick_d;
    logic                boundary, apply, cut;
    logic [NUM_TAPS-1:0] taps_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StStop;
            cnt_q   <= '0;
            act_q   <= DivRst;
            pend_q  <= DivRst;
            busy_q  <= 1'b0;
            p_q     <= 1'b0;
            tick_q  <= 1'b0;
            taps_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            p_q     <= p_d;
            tick_q  <= tick_d;
            taps_q  <= taps_q + NUM_TAPS'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        act_d    = act_q;
        pend_d   = pend_q;
        busy_d   = busy_q;
        boundary = 1'b0;
        apply    = 1'b0;
        case (state_q)
            StStop: begin
                cnt_d = '0;
                apply = busy_q;
                if (en) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                boundary = (cnt_q == act_q - DIV_W'(1));
                apply    = boundary & busy_q;
                cnt_d    = boundary ? '0 : cnt_q + DIV_W'(1);
                if (boundary && !en) begin
                    state_d = StStop;
                end
            end
        endcase
        if (apply) begin
            act_d  = pend_q;
            busy_d = 1'b0;
        end
        // A load seen in a boundary cycle only lands in pend, so it waits one more period.
        if (div_load) begin
            pend_d = DIV_W'(clamp_div(32'(div_i)));
            busy_d = 1'b1;
        end
    end

    // Phase and tick are registered from next-state values so they line up with the edge.
    always_comb begin
        half_d = DIV_W'(half_hi(32'(act_d)));
        half_q = DIV_W'(half_hi(32'(act_q)));
        p_d    = (state_d == StRun) && (cnt_d < half_d);
        tick_d = (state_d == StRun) && (cnt_d == '0);
        cut    = (state_q == StRun) && act_q[0] && (cnt_q == half_q - DIV_W'(1));
    end

    clk_div_oddfix u_oddfix (
        .clk     (clk),
        .rst     (rst),
        .p       (p_q),
        .cut     (cut),
        .odd     (act_q[0]),
        .clk_out (clk_out)
    );

    assign tick = tick_q;
    assign busy = busy_q;
    assign taps = taps_q;

endmodule
